// File: rtl/data_mem_responder.sv
// Single-port data memory that answers load/store requests after a fixed number of wait states.
// Define DMEM_RANGE_CHECK_EN to flag (and suppress) accesses outside the mapped window.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_mem,
   input  logic        wmem_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_i,
   input  logic [3:0]  wmask,
   output logic [31:0] data_o,
   output logic        data_err,
   output logic        data_stall
);

   localparam int unsigned AW        = $clog2(DEPTH_WORDS);
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
   localparam logic [32:0] END_ADDR  = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          stall_d;
   logic          accept, complete;

   logic [31:0]   addr_p0, data_p0;
   logic [3:0]    wmask_p0;
   logic          wmem_p0;

   logic          acc_wmem;
   logic [31:0]   acc_addr, acc_data, acc_off;
   logic [3:0]    acc_wmask;
   logic [AW-1:0] acc_idx;
   logic          acc_bad;
   logic          unused_off;

   logic [31:0]   mem [DEPTH_WORDS];

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  m);
      logic [31:0] r;
      r = old_w;
      for (int n = 0; n < 4; n++)
         if (m[n]) r[8*n +: 8] = new_w[8*n +: 8];
      return r;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall_d  = 1'b0;
      accept   = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_mem) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  complete = 1'b1;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
                  stall_d = 1'b1;
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               complete = 1'b1;
               state_d  = IDLE;
            end else begin
               stall_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Zero-wait accesses complete straight from the ports; waited ones from the latched copy.
   assign acc_wmem  = (state_q == IDLE) ? wmem_i : wmem_p0;
   assign acc_addr  = (state_q == IDLE) ? addr_i : addr_p0;
   assign acc_data  = (state_q == IDLE) ? data_i : data_p0;
   assign acc_wmask = (state_q == IDLE) ? wmask  : wmask_p0;
   assign acc_off   = acc_addr - BASE_ADDR;
   assign acc_idx   = acc_off[AW+1:2];
   assign unused_off = ^{acc_off[31:AW+2], acc_off[1:0]};

`ifdef DMEM_RANGE_CHECK_EN
   assign acc_bad = (acc_addr < BASE_ADDR) || ({1'b0, acc_addr} >= END_ADDR);
`else
   assign acc_bad = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (accept) begin
         addr_p0  <= addr_i;
         data_p0  <= data_i;
         wmask_p0 <= wmask;
         wmem_p0  <= wmem_i;
      end
   end

   // A reset held across an edge must never let a write through.
   always_ff @(posedge clk) begin
      if (complete && acc_wmem && !acc_bad && !reset)
         mem[acc_idx] <= merge_lanes(mem[acc_idx], acc_data, acc_wmask);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         data_stall <= 1'b0;
         data_err   <= 1'b0;
         data_o     <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         data_stall <= stall_d;
         data_err   <= complete && acc_bad;
         if (complete && acc_bad)
            data_o <= 32'd0;
         else if (complete && !acc_wmem)
            data_o <= mem[acc_idx];
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance per wait-state setting 0..3.
module tb_data_mem_responder;

   logic clk = 1'b0;
   logic reset;
   logic [3:0]       req, wm;
   logic [3:0][31:0] ad, di;
   logic [3:0][3:0]  mk;
   wire  [3:0][31:0] dout;
   wire  [3:0]       err, stl;

   int n_pass  = 0;
   int n_total = 0;

`ifdef DMEM_RANGE_CHECK_EN
   localparam logic RC = 1'b1;
`else
   localparam logic RC = 1'b0;
`endif

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      data_mem_responder #(.WAIT_CYCLES(g)) u_dut (
         .clk        (clk),
         .reset      (reset),
         .req_mem    (req[g]),
         .wmem_i     (wm[g]),
         .addr_i     (ad[g]),
         .data_i     (di[g]),
         .wmask      (mk[g]),
         .data_o     (dout[g]),
         .data_err   (err[g]),
         .data_stall (stl[g])
      );
   end

   typedef struct {
      int          k;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  mask;
      int          stall;
      logic [31:0] rdata;
      logic        err;
      string       nm;
   } vec_t;

   vec_t vt [$];

   task automatic check_word(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
   endtask

   task automatic check_bit(input string nm, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", nm, act, exp);
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic add_vec(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m, input int st, input logic [31:0] rd,
                          input logic e, input string nm);
      vec_t v;
      v.k = k; v.wr = wr; v.addr = a; v.data = d; v.mask = m;
      v.stall = st; v.rdata = rd; v.err = e; v.nm = nm;
      vt.push_back(v);
   endtask

   // Called at a falling edge; returns just after the completion edge, then realigns to a falling edge.
   task automatic access(input int k, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, output int ns, output logic [31:0] rd, output logic e);
      req[k] = 1'b1; wm[k] = wr; ad[k] = a; di[k] = d; mk[k] = m;
      @(posedge clk); #1;
      req[k] = 1'b0;
      ns = 0;
      while (stl[k] === 1'b1 && ns < 20) begin
         ns++;
         @(posedge clk); #1;
      end
      rd = dout[k];
      e  = err[k];
      @(negedge clk);
   endtask

   initial begin
      int          ns;
      logic [31:0] rd;
      logic        e;

      reset = 1'b1;
      req = '0; wm = '0; ad = '0; di = '0; mk = '0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 4; g++) begin
         check_word($sformatf("rst_data_o_%0d", g), dout[g], 32'd0);
         check_bit ($sformatf("rst_err_%0d", g), err[g], 1'b0);
         check_bit ($sformatf("rst_stall_%0d", g), stl[g], 1'b0);
      end
      reset = 1'b0;

      add_vec(2, 1'b1, 32'h1010, 32'hDEAD_BEEF, 4'hF, 2, 32'h0,         1'b0, "w2_store");
      add_vec(2, 1'b0, 32'h1010, 32'h0,         4'h0, 2, 32'hDEAD_BEEF, 1'b0, "w2_load");
      add_vec(0, 1'b1, 32'h1000, 32'h1122_3344, 4'hF, 0, 32'h0,         1'b0, "w0_preset");
      add_vec(0, 1'b1, 32'h1000, 32'hAABB_CCDD, 4'h5, 0, 32'h0,         1'b0, "w0_lane_store");
      add_vec(0, 1'b0, 32'h1000, 32'h0,         4'h0, 0, 32'h11BB_33DD, 1'b0, "w0_lane_load");
      add_vec(0, 1'b1, 32'h1004, 32'h5566_7788, 4'hF, 0, 32'h11BB_33DD, 1'b0, "w0_store4");
      add_vec(0, 1'b1, 32'h1008, 32'h99AA_BBCC, 4'hF, 0, 32'h11BB_33DD, 1'b0, "w0_store8");
      add_vec(0, 1'b1, 32'h1006, 32'hFFFF_FFFF, 4'h0, 0, 32'h11BB_33DD, 1'b0, "w0_nomask");
      add_vec(0, 1'b0, 32'h1007, 32'h0,         4'h0, 0, 32'h5566_7788, 1'b0, "w0_load4");
      add_vec(1, 1'b1, 32'h1FFC, 32'hCAFE_F00D, 4'hF, 1, 32'h0,         1'b0, "w1_store_top");
      add_vec(1, 1'b0, 32'h0FFC, 32'h0,         4'h0, 1, RC ? 32'h0 : 32'hCAFE_F00D, RC, "w1_load_low");
      add_vec(1, 1'b1, 32'h1004, 32'h0102_0304, 4'hF, 1, RC ? 32'h0 : 32'hCAFE_F00D, 1'b0, "w1_store4");
      add_vec(1, 1'b0, 32'h2004, 32'h0,         4'h0, 1, RC ? 32'h0 : 32'h0102_0304, RC, "w1_load_high");
      add_vec(1, 1'b0, 32'h1004, 32'h0,         4'h0, 1, 32'h0102_0304, 1'b0, "w1_load4");
      add_vec(3, 1'b1, 32'h1020, 32'h1357_9BDF, 4'hF, 3, 32'h0,         1'b0, "w3_store");
      add_vec(3, 1'b0, 32'h1020, 32'h0,         4'h0, 3, 32'h1357_9BDF, 1'b0, "w3_load");
      add_vec(2, 1'b1, 32'h1034, 32'h1234_5678, 4'hF, 2, 32'hDEAD_BEEF, 1'b0, "w2_store34");

      for (int i = 0; i < vt.size(); i++) begin
         access(vt[i].k, vt[i].wr, vt[i].addr, vt[i].data, vt[i].mask, ns, rd, e);
         check_int ($sformatf("%s_stall", vt[i].nm), ns, vt[i].stall);
         check_word($sformatf("%s_data", vt[i].nm), rd, vt[i].rdata);
         check_bit ($sformatf("%s_err", vt[i].nm), e, vt[i].err);
         @(posedge clk); #1;
         check_bit ($sformatf("%s_err_next", vt[i].nm), err[vt[i].k], 1'b0);
         @(negedge clk);
      end

      // Back-to-back zero-wait loads on consecutive edges
      req[0] = 1'b1; wm[0] = 1'b0; ad[0] = 32'h1000;
      @(posedge clk); #1;
      check_word("b2b_load0", dout[0], 32'h11BB_33DD);
      check_bit ("b2b_stall0", stl[0], 1'b0);
      ad[0] = 32'h1004;
      @(posedge clk); #1;
      check_word("b2b_load1", dout[0], 32'h5566_7788);
      ad[0] = 32'h1008;
      @(posedge clk); #1;
      check_word("b2b_load2", dout[0], 32'h99AA_BBCC);
      check_bit ("b2b_stall2", stl[0], 1'b0);
      req[0] = 1'b0;
      @(posedge clk); #1;
      check_word("idle_hold", dout[0], 32'h99AA_BBCC);
      check_bit ("idle_err", err[0], 1'b0);
      @(negedge clk);

      // Requester scribbles on the bus during the wait states
      req[2] = 1'b1; wm[2] = 1'b1; ad[2] = 32'h1030; di[2] = 32'h0BAD_C0DE; mk[2] = 4'hF;
      @(posedge clk); #1;
      check_bit("hold_stall1", stl[2], 1'b1);
      ad[2] = 32'h1034; di[2] = 32'hFFFF_FFFF; mk[2] = 4'h3;
      @(posedge clk); #1;
      check_bit("hold_stall2", stl[2], 1'b1);
      ad[2] = 32'h1010; di[2] = 32'h0; wm[2] = 1'b0;
      @(posedge clk); #1;
      check_bit("hold_done", stl[2], 1'b0);
      req[2] = 1'b0;
      @(negedge clk);
      access(2, 1'b0, 32'h1030, 32'h0, 4'h0, ns, rd, e);
      check_word("hold_latched", rd, 32'h0BAD_C0DE);
      access(2, 1'b0, 32'h1034, 32'h0, 4'h0, ns, rd, e);
      check_word("hold_other", rd, 32'h1234_5678);
      access(2, 1'b0, 32'h1010, 32'h0, 4'h0, ns, rd, e);
      check_word("hold_third", rd, 32'hDEAD_BEEF);

      // Reset in the second wait cycle aborts the store
      req[3] = 1'b1; wm[3] = 1'b1; ad[3] = 32'h1020; di[3] = 32'hFFFF_0000; mk[3] = 4'hF;
      @(posedge clk); #1;
      req[3] = 1'b0;
      check_bit("abort_stall1", stl[3], 1'b1);
      @(posedge clk); #1;
      check_bit ("abort_stall2", stl[3], 1'b1);
      check_word("abort_pre_data", dout[3], 32'h1357_9BDF);
      reset = 1'b1;
      #1;
      check_word("abort_data_o", dout[3], 32'd0);
      check_bit ("abort_stall", stl[3], 1'b0);
      check_bit ("abort_err", err[3], 1'b0);
      @(negedge clk);
      reset = 1'b0;
      access(3, 1'b0, 32'h1020, 32'h0, 4'h0, ns, rd, e);
      check_int ("post_rst_stall", ns, 3);
      check_word("post_rst_data", rd, 32'h1357_9BDF);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: number of 32-bit words; power of two, at least 2.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_1000: byte address of word 0; aligned to 4*DEPTH_WORDS.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: wait states per access, 0..15.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req_mem  input  1  access request, load or store.
REQ-007 wmem_i  input  1  1 = store, 0 = load; qualified by req_mem.
REQ-008 addr_i  input  32  byte address; bits [1:0] ignored.
REQ-009 data_i  input  32  store data.
REQ-010 wmask  input  4  byte-lane write enables; bit n enables byte lane n (data_i[8n+7:8n]).
REQ-011 data_o  output  32  registered load data.
REQ-012 data_err  output  1  registered one-cycle access-error pulse.
REQ-013 data_stall  output  1  registered busy flag; requester holds its request while high.

Function
REQ-014 SHALL implement FSM states IDLE and WAIT with a 4-bit wait counter.
REQ-015 In IDLE, a rising edge with req_mem=1 SHALL accept the request and latch addr_i, wmem_i, data_i and wmask.
REQ-016 Word index SHALL be (addr - BASE_ADDR)[log2(DEPTH_WORDS)+1:2].
REQ-017 With WAIT_CYCLES=0, the access SHALL complete on the accepting edge, the FSM SHALL stay in IDLE, and back-to-back requests on consecutive cycles SHALL each be serviced.
REQ-018 With WAIT_CYCLES=W>0, the accepting edge SHALL:
- set the counter to W;
- move the FSM to WAIT;
- set data_stall=1.
REQ-019 In WAIT, each edge SHALL decrement the counter. On the edge where the counter equals 1, the latched access SHALL complete, data_stall SHALL clear and the FSM SHALL return to IDLE. data_stall is therefore high for exactly W cycles.
REQ-020 In WAIT, req_mem, addr_i, wmem_i, data_i and wmask SHALL be ignored. A new request is accepted only in IDLE, so the earliest next acceptance is the edge after data_stall falls.
REQ-021 Load completion SHALL load data_o with the full addressed word. Byte and halfword extraction is the requester's job.
REQ-022 data_o SHALL hold its value until the next load completion; store completion SHALL leave data_o unchanged.
REQ-023 Store completion SHALL write only the byte lanes whose wmask bit is set. wmask=0 SHALL leave memory unchanged and SHALL NOT raise an error.
REQ-024 data_err SHALL be high for exactly the one cycle following an erroring completion edge, and low otherwise.
REQ-025 With no request in IDLE, outputs SHALL hold, except data_err, which returns to 0.

Reset
REQ-026 Reset SHALL force IDLE, counter=0, data_o=0, data_err=0 and data_stall=0.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 Reset asserted during WAIT SHALL abort the pending access with no memory write.
REQ-029 The first request SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro DMEM_RANGE_CHECK_EN defined:
- an access with addr_i < BASE_ADDR or addr_i >= BASE_ADDR + 4*DEPTH_WORDS SHALL complete with the same stall timing;
- it SHALL perform no write and set data_o=0;
- it SHALL pulse data_err.
REQ-031 Macro DMEM_RANGE_CHECK_EN undefined:
- no range check; addresses SHALL wrap modulo 4*DEPTH_WORDS using the index of REQ-016;
- data_err SHALL be tied to 0.

Verification
REQ-032 W=2: store 32'hDEAD_BEEF to 0x1010, wmask=4'hF -> data_stall high for 2 cycles; then load 0x1010 -> data_o=32'hDEAD_BEEF in the cycle data_stall falls.
REQ-033 W=0: word 0x1000 preset to 32'h1122_3344; store 32'hAABB_CCDD with wmask=4'b0101, then load -> data_o=32'h11BB_33DD with no stall on either access.
REQ-034 W=0: loads on three consecutive cycles from 0x1000, 0x1004, 0x1008 -> data_o shows the three words on three consecutive cycles, data_stall never high.
REQ-035 DMEM_RANGE_CHECK_EN defined, W=1: load from 0x0FFC -> data_err high one cycle, data_o=0. Same stimulus with the macro undefined -> data_err=0 and the wrapped word (index DEPTH_WORDS-1) is returned.
REQ-036 W=3: store issued, reset asserted during the second stall cycle -> all outputs 0 immediately; a later load of that address returns its prior contents.
REQ-037 W=2: requester changes addr_i and data_i during WAIT -> the originally latched address and data are used.
